// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD card command/response path.
// Holds the FSM state encoding, R1 bit positions and timing defaults.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_R1      = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int R1_IDLE        = 0;
  localparam int R1_ILLEGAL_CMD = 2;

  // The card holds DO high when idle, so an untouched R1 reads as all ones.
  localparam logic [7:0] R1_NONE = 8'hFF;

  localparam int DEFAULT_TIMEOUT = 80;

  localparam int R1_BITS      = 8;
  localparam int PAYLOAD_BITS = 32;

endpackage

// File: rtl/sd_shift_in.sv
// MSB-first serial-to-parallel shifter: one bit per enabled cycle, clear has priority.
// Latency 1 cycle per bit; no backpressure, caller gates enable.
module sd_shift_in
  import sd_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic [5:0]       bitCount
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data     <= CLEAR_VAL;
      bitCount <= 6'd0;
    end else if (clear) begin
      data     <= CLEAR_VAL;
      bitCount <= 6'd0;
    end else if (enable) begin
      data <= {data[WIDTH-2:0], din};
      if (bitCount != 6'h3F) begin
        bitCount <= bitCount + 6'd1;
      end
    end
  end

endmodule

// File: rtl/sd_resp_rx.sv
// SPI-mode SD response receiver: hunts DO for a start bit, captures R1 and optional 32-bit trailer.
// Short response done 8 edges after start bit, long 40; level isStart/isBusy/isFinish handshake, DONE held until isStart drops.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isStart,
  input  logic        respLong,
  input  logic        DO,
  output logic        isBusy,
  output logic        isFinish,
  output logic        isTimeout,
  output logic [7:0]  r1,
  output logic [31:0] payload
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic          longLatched;
  logic [TW-1:0] tcnt;
  logic [5:0]    r1Count;
  logic [5:0]    payCount;
  logic          shiftClear;
  logic          r1En;
  logic          payEn;

  assign shiftClear = (state == S_IDLE) && isStart;
  assign r1En       = ((state == S_WAIT) && !DO) || (state == S_R1);
  assign payEn      = (state == S_PAYLOAD);

  sd_shift_in #(
    .WIDTH     (R1_BITS),
    .CLEAR_VAL (R1_NONE)
  ) u_r1Shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (shiftClear),
    .enable   (r1En),
    .din      (DO),
    .data     (r1),
    .bitCount (r1Count)
  );

  sd_shift_in #(
    .WIDTH     (PAYLOAD_BITS),
    .CLEAR_VAL ('0)
  ) u_payShift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (shiftClear),
    .enable   (payEn),
    .din      (DO),
    .data     (payload),
    .bitCount (payCount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      isBusy      <= 1'b0;
      isFinish    <= 1'b0;
      isTimeout   <= 1'b0;
      longLatched <= 1'b0;
      tcnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          isBusy   <= 1'b0;
          isFinish <= 1'b0;
          if (isStart) begin
            longLatched <= respLong;
            isTimeout   <= 1'b0;
            tcnt        <= '0;
            isBusy      <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!DO) begin
            state <= S_R1;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            isTimeout <= 1'b1;
            isFinish  <= 1'b1;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_R1: begin
          if (r1Count == 6'(R1_BITS - 1)) begin
            // r1 has not shifted yet on this edge, so the final bit 2 is still at bit 1.
            if (!longLatched || r1[R1_ILLEGAL_CMD-1]) begin
              isFinish <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (payCount == 6'(PAYLOAD_BITS - 1)) begin
            isFinish <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (!isStart) begin
            isBusy   <= 1'b0;
            isFinish <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          isBusy   <= 1'b0;
          isFinish <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_sd_resp_rx;
  import sd_pkg::*;

  localparam int TO = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        isStart = 1'b0;
  logic        respLong = 1'b0;
  logic        DO = 1'b1;
  logic        isBusy;
  logic        isFinish;
  logic        isTimeout;
  logic [7:0]  r1;
  logic [31:0] payload;

  sd_resp_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .isStart   (isStart),
    .respLong  (respLong),
    .DO        (DO),
    .isBusy    (isBusy),
    .isFinish  (isFinish),
    .isTimeout (isTimeout),
    .r1        (r1),
    .payload   (payload)
  );

  always #5 clk = ~clk;

  int edgeNo = 0;
  always @(posedge clk) edgeNo++;

  typedef struct {
    int          id;
    logic        to;
    logic [7:0]  r1v;
    logic [31:0] pay;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acceptEdge = 0;
  int   nChecks = 0;
  int   nFails = 0;
  logic prevFin = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every rising isFinish must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (isFinish && !prevFin) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_finish: got finish at edge %0d, expected none", edgeNo);
      end else begin
        e = sb.pop_front();
        check($sformatf("f%0d_timeout", e.id), 64'(isTimeout), 64'(e.to));
        check($sformatf("f%0d_r1", e.id), 64'(r1), 64'(e.r1v));
        check($sformatf("f%0d_payload", e.id), 64'(payload), 64'(e.pay));
        check($sformatf("f%0d_latency", e.id), 64'(edgeNo - acceptEdge), 64'(e.lat));
        check($sformatf("f%0d_busy", e.id), 64'(isBusy), 64'(1));
        check($sformatf("f%0d_state", e.id), 64'(dut.state), 64'(S_DONE));
      end
    end
    prevFin = isFinish;
  end

  task automatic pushExp(input int id, input logic to, input logic [7:0] r1v,
                         input logic [31:0] pay, input int lat);
    exp_t e;
    e.id = id; e.to = to; e.r1v = r1v; e.pay = pay; e.lat = lat;
    sb.push_back(e);
  endtask

  // holdAfter >= 0 keeps isStart high that many cycles past isFinish; abortBit > 0 resets during that payload bit.
  task automatic runFrame(input logic lng, input int preOnes, input bit hasR1, input logic [7:0] r1v,
                          input int nPay, input logic [31:0] pay, input int holdAfter, input int abortBit);
    int n;
    @(negedge clk);
    isStart  = 1'b1;
    respLong = lng;
    DO       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acceptEdge = edgeNo;
    check("accept_busy", 64'(isBusy), 64'(1));
    check("accept_r1_clear", 64'(r1), 64'(8'hFF));
    check("accept_payload_clear", 64'(payload), 64'(0));
    if (holdAfter < 0) isStart = 1'b0;
    respLong = ~lng;
    for (int i = 0; i < preOnes; i++) begin
      DO = 1'b1;
      @(negedge clk);
    end
    if (hasR1) begin
      for (int i = 7; i >= 0; i--) begin
        DO = r1v[i];
        @(negedge clk);
      end
    end
    for (int i = 0; i < nPay; i++) begin
      DO = pay[31-i];
      if (abortBit == i + 1) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(isBusy), 64'(0));
        check("rst_finish", 64'(isFinish), 64'(0));
        check("rst_timeout", 64'(isTimeout), 64'(0));
        check("rst_r1", 64'(r1), 64'(8'hFF));
        check("rst_payload", 64'(payload), 64'(0));
        check("rst_state", 64'(dut.state), 64'(S_IDLE));
        DO = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    DO = 1'b1;
    if (holdAfter >= 0) begin
      n = 0;
      while (!isFinish && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("hold_finish_seen", 64'(isFinish), 64'(1));
      for (int k = 0; k < holdAfter; k++) begin
        @(negedge clk);
        check("hold_finish", 64'(isFinish), 64'(1));
        check("hold_busy", 64'(isBusy), 64'(1));
      end
      isStart = 1'b0;
      @(negedge clk);
      check("drop_finish", 64'(isFinish), 64'(0));
      check("drop_busy", 64'(isBusy), 64'(0));
    end else begin
      n = 0;
      while (isBusy && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("frame_idle", 64'(isBusy), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(isBusy), 64'(0));
    check("reset_finish", 64'(isFinish), 64'(0));
    check("reset_timeout", 64'(isTimeout), 64'(0));
    check("reset_r1", 64'(r1), 64'(8'hFF));
    check("reset_payload", 64'(payload), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short R1 after three idle ones.
    pushExp(1, 1'b0, 8'h01, 32'h0, 11);
    runFrame(1'b0, 3, 1'b1, 8'h01, 0, 32'h0, -1, -1);
    // Long R7-style response.
    pushExp(2, 1'b0, 8'h01, 32'h0000_01AA, 40);
    runFrame(1'b1, 0, 1'b1, 8'h01, 32, 32'h0000_01AA, -1, -1);
    // Illegal command: trailer skipped.
    pushExp(3, 1'b0, 8'h05, 32'h0, 8);
    runFrame(1'b1, 0, 1'b1, 8'h05, 0, 32'h0, -1, -1);
    // All-zero R1, short.
    pushExp(4, 1'b0, 8'h00, 32'h0, 8);
    runFrame(1'b0, 0, 1'b1, 8'h00, 0, 32'h0, -1, -1);
    // Long with a mixed trailer after one idle one.
    pushExp(5, 1'b0, 8'h00, 32'hC0FF_EE5A, 41);
    runFrame(1'b1, 1, 1'b1, 8'h00, 32, 32'hC0FF_EE5A, -1, -1);
    // Timeout: DO never drops.
    pushExp(6, 1'b1, 8'hFF, 32'h0, TO);
    runFrame(1'b0, TO, 1'b0, 8'h00, 0, 32'h0, -1, -1);
    // Start bit on the last sample before timeout.
    pushExp(7, 1'b0, 8'h01, 32'h0, TO - 2 + 8);
    runFrame(1'b0, TO - 2, 1'b1, 8'h01, 0, 32'h0, -1, -1);
    // Reset during payload bit 20, then a fresh reception.
    runFrame(1'b1, 0, 1'b1, 8'h01, 32, 32'hDEAD_BEEF, -1, 20);
    pushExp(8, 1'b0, 8'h01, 32'h0, 11);
    runFrame(1'b0, 3, 1'b1, 8'h01, 0, 32'h0, -1, -1);
    // isStart held past finish, then a re-raised start.
    pushExp(9, 1'b0, 8'h01, 32'h0, 8);
    runFrame(1'b0, 0, 1'b1, 8'h01, 0, 32'h0, 5, -1);
    pushExp(10, 1'b0, 8'h3C, 32'h0, 10);
    runFrame(1'b0, 2, 1'b1, 8'h3C, 0, 32'h0, -1, -1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
